// File: rtl/regfile_rename.sv
// Architectural register file plus rename table (busy bit and ROB tag per register).
// Optional COMMIT_BYPASS_EN forwards the committing value to pending operands in the commit cycle.
module regfile_rename #(
    parameter int ROB_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,
    input  logic             dec_ready,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    input  logic             dec_wr_rd,
    input  logic [ROB_W-1:0] dec_rob_id,
    output logic [31:0]      op_val1,
    output logic [31:0]      op_val2,
    output logic             op_dep1,
    output logic             op_dep2,
    output logic [ROB_W-1:0] op_tag1,
    output logic [ROB_W-1:0] op_tag2,
    output logic [ROB_W-1:0] search_rob_id_1,
    output logic [ROB_W-1:0] search_rob_id_2,
    input  logic             search_ready_1,
    input  logic             search_ready_2,
    input  logic [31:0]      search_val_1,
    input  logic [31:0]      search_val_2,
    input  logic             commit_ready,
    input  logic [ROB_W-1:0] commit_rob_id,
    input  logic [4:0]       commit_reg_id,
    input  logic [31:0]      commit_val
);

    typedef struct packed {
        logic [31:0] val;
        logic        dep;
    } operand_t;

    logic [31:0]      regs_q [32];
    logic [31:0]      regs_d [32];
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;
    logic [ROB_W-1:0] tag_q  [32];
    logic [ROB_W-1:0] tag_d  [32];

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            if (commit_ready && commit_reg_id != 5'd0) begin
                regs_d[commit_reg_id] = commit_val;
                // Only the newest writer may free the register; an older tag leaves it busy.
                if (busy_q[commit_reg_id] && tag_q[commit_reg_id] == commit_rob_id)
                    busy_d[commit_reg_id] = 1'b0;
            end
            if (clear) begin
                busy_d = '0;
                for (int i = 0; i < 32; i++) tag_d[i] = '0;
            end else if (dec_ready && dec_wr_rd && dec_rd != 5'd0) begin
                busy_d[dec_rd] = 1'b1;
                tag_d[dec_rd]  = dec_rob_id;
            end
        end
    end

    // NOTE: the register array is reset because architectural state must read 0 after reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            tag_q  <= '{default: '0};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    function automatic operand_t read_op(input logic [4:0] rs, input logic s_rdy,
                                         input logic [31:0] s_val);
        operand_t r;
        r.val = 32'd0;
        r.dep = 1'b0;
        if (!busy_q[rs]) begin
            r.val = regs_q[rs];
`ifdef COMMIT_BYPASS_EN
        end else if (rs != 5'd0 && commit_ready && commit_rob_id == tag_q[rs]) begin
            r.val = commit_val;
`endif
        end else if (s_rdy) begin
            r.val = s_val;
        end else begin
            r.dep = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        operand_t o1;
        operand_t o2;
        o1 = read_op(dec_rs1, search_ready_1, search_val_1);
        o2 = read_op(dec_rs2, search_ready_2, search_val_2);
        op_val1         = o1.val;
        op_dep1         = o1.dep;
        op_val2         = o2.val;
        op_dep2         = o2.dep;
        op_tag1         = tag_q[dec_rs1];
        op_tag2         = tag_q[dec_rs2];
        search_rob_id_1 = tag_q[dec_rs1];
        search_rob_id_2 = tag_q[dec_rs2];
    end

endmodule
